// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: load types, FSM states and alignment helpers.
// The optional misaligned-load exception is enabled by defining MEM_ALIGN_EXC_EN.
package mem_pkg;

   // ld_type = {sext, size[1:0]}
   localparam logic [2:0] LD_BU = 3'b000;
   localparam logic [2:0] LD_HU = 3'b001;
   localparam logic [2:0] LD_WU = 3'b010;
   localparam logic [2:0] LD_B  = 3'b100;
   localparam logic [2:0] LD_H  = 3'b101;
   localparam logic [2:0] LD_W  = 3'b110;
   localparam logic [2:0] LD_D  = 3'b111;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_WAIT  = 2'b01;
   localparam logic [1:0] ST_HOLD  = 2'b10;
   localparam logic [1:0] ST_DRAIN = 2'b11;

   // A doubleword request on a 32-bit datapath degrades to a word access.
   function automatic logic [1:0] mem_eff_size(input logic [2:0] ld_type, input logic dw64);
      mem_eff_size = (ld_type[1:0] == 2'b11 && !dw64) ? 2'b10 : ld_type[1:0];
   endfunction

   function automatic logic mem_is_misaligned(input logic [2:0] ld_type,
                                              input logic [2:0] addr_lo,
                                              input logic       dw64);
      case (mem_eff_size(ld_type, dw64))
         2'b00:   mem_is_misaligned = 1'b0;
         2'b01:   mem_is_misaligned = addr_lo[0];
         2'b10:   mem_is_misaligned = |addr_lo[1:0];
         default: mem_is_misaligned = |addr_lo;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// EX->MEM and MEM->WB handshake bundle. Valid/ready: a beat transfers on a cycle where
// valid and ready are both high; the sender holds its payload stable until that cycle.
interface mem_stage_hs_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int PASS_W = 67
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_pc;
   logic [DATA_W-1:0] in_result;
   logic              in_is_load;
   logic [2:0]        in_ld_type;
   logic              in_rf_we;
   logic [4:0]        in_rf_waddr;
   logic [PASS_W-1:0] in_pass;

   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_pc;
   logic              out_rf_we;
   logic [4:0]        out_rf_waddr;
   logic [DATA_W-1:0] out_rf_wdata;
   logic [PASS_W-1:0] out_pass;

   modport master (
      output in_valid, in_pc, in_result, in_is_load, in_ld_type, in_rf_we, in_rf_waddr, in_pass,
      output out_ready,
      input  in_ready,
      input  out_valid, out_pc, out_rf_we, out_rf_waddr, out_rf_wdata, out_pass
   );

   modport slave (
      input  in_valid, in_pc, in_result, in_is_load, in_ld_type, in_rf_we, in_rf_waddr, in_pass,
      input  out_ready,
      output in_ready,
      output out_valid, out_pc, out_rf_we, out_rf_waddr, out_rf_wdata, out_pass
   );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load formatter: selects the addressed field of the SRAM word and
// zero- or sign-extends it to the datapath width.
module mem_load_align
   import mem_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int LANE_W = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0] rdata,
   input  logic [LANE_W-1:0] lane,
   input  logic [2:0]        ld_type,
   output logic [DATA_W-1:0] data
);
   logic [1:0]        size;
   logic [2:0]        amask;
   int                nbits;
   logic [LANE_W-1:0] lane_al;
   logic [DATA_W-1:0] sh;
   logic [DATA_W-1:0] mask;
   logic [DATA_W-1:0] top_bit;
   logic              sign;

   always_comb begin
      size  = mem_eff_size(ld_type, DATA_W == 64);
      amask = 3'b000;
      nbits = 8;
      case (size)
         2'b00:   begin amask = 3'b000; nbits = 8;  end
         2'b01:   begin amask = 3'b001; nbits = 16; end
         2'b10:   begin amask = 3'b011; nbits = 32; end
         default: begin amask = 3'b111; nbits = 64; end
      endcase
      // Low lane bits below the access size are dropped (aligned down).
      lane_al = lane & ~amask[LANE_W-1:0];
      sh      = rdata >> {lane_al, 3'b000};
      if (nbits >= DATA_W) mask = '1;
      else                 mask = (DATA_W'(1) << nbits) - DATA_W'(1);
      top_bit = mask ^ (mask >> 1);
      sign    = |(sh & top_bit);
      data    = (sh & mask) | ((ld_type[2] && sign) ? ~mask : '0);
   end
endmodule

// File: rtl/mem_stage_hs.sv
// Single-entry MEM stage: holds one instruction, waits for load data, formats it, hands off to WB.
// Define MEM_ALIGN_EXC_EN to flag misaligned loads instead of silently aligning them down.
module mem_stage_hs
   import mem_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 32,
   parameter  int PASS_W = 67,
   localparam int LANE_W = $clog2(DATA_W / 8)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   mem_stage_hs_if.slave     bus,
   input  logic              rdata_valid,
   input  logic [DATA_W-1:0] rdata,
   output logic              fwd_we,
   output logic [4:0]        fwd_waddr,
   output logic [DATA_W-1:0] fwd_wdata,
   output logic              fwd_pending,
   output logic              exc_misalign,
   output logic [1:0]        state_dbg
);
   logic [1:0]        state_q;
   logic [ADDR_W-1:0] pc_q;
   logic              we_q;
   logic [4:0]        waddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [PASS_W-1:0] pass_q;
   logic [2:0]        ld_type_q;
   logic [LANE_W-1:0] lane_q;
   logic [DATA_W-1:0] ld_data;
   logic              mis_hold;
   logic              take;

   // Flush wins over acceptance: in_ready stays up but the entry is not captured.
   assign bus.in_ready = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus.out_ready));
   assign take         = bus.in_valid & bus.in_ready & ~flush;

   mem_load_align #(.DATA_W(DATA_W)) u_align (
      .rdata   (rdata),
      .lane    (lane_q),
      .ld_type (ld_type_q),
      .data    (ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         pass_q    <= '0;
         ld_type_q <= '0;
         lane_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE:
               if (take) state_q <= bus.in_is_load ? ST_WAIT : ST_HOLD;
            ST_WAIT:
               if (flush) state_q <= rdata_valid ? ST_IDLE : ST_DRAIN;
               else if (rdata_valid) begin
                  state_q <= ST_HOLD;
                  wdata_q <= ld_data;
               end
            ST_HOLD:
               if (flush) state_q <= ST_IDLE;
               else if (bus.out_ready)
                  state_q <= take ? (bus.in_is_load ? ST_WAIT : ST_HOLD) : ST_IDLE;
            ST_DRAIN:
               if (rdata_valid) state_q <= ST_IDLE;
            default:
               state_q <= ST_IDLE;
         endcase
         if (take) begin
            pc_q      <= bus.in_pc;
            we_q      <= bus.in_rf_we;
            waddr_q   <= bus.in_rf_waddr;
            wdata_q   <= bus.in_result;
            pass_q    <= bus.in_pass;
            ld_type_q <= bus.in_ld_type;
            lane_q    <= bus.in_result[LANE_W-1:0];
         end
      end
   end

`ifdef MEM_ALIGN_EXC_EN
   logic mis_q;
   always_ff @(posedge clk) begin
      if (rst)       mis_q <= 1'b0;
      else if (take) mis_q <= bus.in_is_load &
                              mem_is_misaligned(bus.in_ld_type, bus.in_result[2:0], DATA_W == 64);
   end
   assign mis_hold     = mis_q & (state_q == ST_HOLD);
   assign exc_misalign = mis_hold;
`else
   assign mis_hold     = 1'b0;
   assign exc_misalign = 1'b0;
`endif

   assign bus.out_valid    = (state_q == ST_HOLD);
   assign bus.out_pc       = pc_q;
   assign bus.out_rf_we    = we_q & ~mis_hold;
   assign bus.out_rf_waddr = waddr_q;
   assign bus.out_rf_wdata = wdata_q;
   assign bus.out_pass     = pass_q;

   // A load in WAIT already claims its destination so ID can interlock on it.
   assign fwd_we      = ((state_q == ST_WAIT) | ((state_q == ST_HOLD) & ~mis_hold)) & we_q;
   assign fwd_pending = (state_q == ST_WAIT) & we_q;
   assign fwd_waddr   = waddr_q;
   assign fwd_wdata   = wdata_q;
   assign state_dbg   = state_q;
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs (32-bit datapath) with a write-data scoreboard on the WB port.
module tb_mem_stage_hs;
   import mem_pkg::*;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        rdata_valid;
   logic [31:0] rdata;
   logic        fwd_we;
   logic [4:0]  fwd_waddr;
   logic [31:0] fwd_wdata;
   logic        fwd_pending;
   logic        exc_misalign;
   logic [1:0]  state_dbg;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   mem_stage_hs_if #(.DATA_W(32), .ADDR_W(32), .PASS_W(67)) bus ();

   mem_stage_hs #(.DATA_W(32), .ADDR_W(32), .PASS_W(67)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .bus          (bus),
      .rdata_valid  (rdata_valid),
      .rdata        (rdata),
      .fwd_we       (fwd_we),
      .fwd_waddr    (fwd_waddr),
      .fwd_wdata    (fwd_wdata),
      .fwd_pending  (fwd_pending),
      .exc_misalign (exc_misalign),
      .state_dbg    (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // scoreboard: every WB handshake must match the oldest expected write data
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) check("unexpected_out", 1, 0);
         else                   check("sb_wdata", bus.out_rf_wdata, exp_q.pop_front());
      end
   end

   // driver: present one instruction and wait (bounded) for acceptance
   task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic ld,
                       input logic [2:0] lt, input logic we, input logic [4:0] wa);
      logic acc;
      acc = 1'b0;
      bus.in_pc = pc; bus.in_result = res; bus.in_is_load = ld; bus.in_ld_type = lt;
      bus.in_rf_we = we; bus.in_rf_waddr = wa; bus.in_pass = {3'b101, 32'hCAFE_0000, pc};
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20 && !acc; i++) begin
         #1 acc = bus.in_ready;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!acc) check("accept_timeout", 0, 1);
   endtask

   task automatic respond(input int wait_cycles, input logic [31:0] d);
      repeat (wait_cycles) begin @(posedge clk); #1; end
      rdata_valid = 1'b1; rdata = d;
      @(posedge clk); #1;
      rdata_valid = 1'b0; rdata = 32'h0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      int pend_cnt;
      int stable;
      rst = 1'b1; flush = 1'b0; rdata_valid = 1'b0; rdata = '0;
      bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_result = '0; bus.in_is_load = 1'b0;
      bus.in_ld_type = '0; bus.in_rf_we = 1'b0; bus.in_rf_waddr = '0; bus.in_pass = '0;
      bus.out_ready = 1'b1;

      // reset
      repeat (3) @(posedge clk);
      #1 check("rst_in_ready", bus.in_ready, 0);
      rst = 1'b0;
      tick();
      check("rst_state", state_dbg, ST_IDLE);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_fwd", {fwd_we, fwd_pending, exc_misalign}, 0);
      check("rst_wdata", bus.out_rf_wdata, 0);
      check("idle_in_ready", bus.in_ready, 1);

      // ALU op passes straight through
      exp_q.push_back(32'h0000_1234);
      send(32'h100, 32'h1234, 1'b0, LD_WU, 1'b1, 5'd5);
      check("alu_out_valid", bus.out_valid, 1);
      check("alu_wdata", bus.out_rf_wdata, 32'h1234);
      check("alu_waddr", bus.out_rf_waddr, 5);
      check("alu_pc", bus.out_pc, 32'h100);
      check("alu_pass", bus.out_pass[63:0], {32'hCAFE_0000, 32'h100});
      check("alu_fwd", {fwd_we, fwd_pending, fwd_waddr}, {2'b10, 5'd5});
      tick();
      check("alu_done", bus.out_valid, 0);

      // LB 0x103 with response in the third waiting cycle
      exp_q.push_back(32'hFFFF_FF80);
      send(32'h104, 32'h103, 1'b1, LD_B, 1'b1, 5'd7);
      pend_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (fwd_pending && fwd_we && !bus.out_valid) pend_cnt++;
         if (i == 2) begin rdata_valid = 1'b1; rdata = 32'h80FF_0000; end
         tick();
      end
      rdata_valid = 1'b0;
      check("lb_pending_cycles", pend_cnt, 3);
      check("lb_out_valid", bus.out_valid, 1);
      check("lb_pending_clr", fwd_pending, 0);
      check("lb_wdata", bus.out_rf_wdata, 32'hFFFF_FF80);
      check("lb_fwd_wdata", fwd_wdata, 32'hFFFF_FF80);
      tick();

      // LHU 0x102; a response during the acceptance cycle must be ignored
      exp_q.push_back(32'h0000_8001);
      rdata_valid = 1'b1; rdata = 32'hDEAD_BEEF;
      send(32'h108, 32'h102, 1'b1, LD_HU, 1'b1, 5'd8);
      rdata_valid = 1'b0;
      check("lhu_still_wait", state_dbg, ST_WAIT);
      respond(0, 32'h8001_7777);
      check("lhu_wdata", bus.out_rf_wdata, 32'h0000_8001);
      tick();

      // backpressure then back-to-back swap
      exp_q.push_back(32'h0000_000A);
      exp_q.push_back(32'h0000_000B);
      bus.out_ready = 1'b0;
      send(32'h200, 32'hA, 1'b0, LD_WU, 1'b1, 5'd1);
      bus.in_pc = 32'h204; bus.in_result = 32'hB; bus.in_rf_waddr = 5'd2; bus.in_valid = 1'b1;
      stable = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.out_valid && bus.out_rf_wdata == 32'hA && bus.out_rf_waddr == 5'd1 && !bus.in_ready)
            stable++;
         tick();
      end
      check("bp_stable", stable, 4);
      bus.out_ready = 1'b1;
      #1 check("swap_in_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      check("swap_no_bubble", bus.out_valid, 1);
      check("swap_wdata", bus.out_rf_wdata, 32'hB);
      tick();
      check("swap_done", bus.out_valid, 0);

      // flush in WAIT, response arrives two cycles later and is dropped
      send(32'h300, 32'h300, 1'b1, LD_W, 1'b1, 5'd9);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("drain_state", state_dbg, ST_DRAIN);
      check("drain_in_ready", bus.in_ready, 0);
      check("drain_fwd", {fwd_we, fwd_pending}, 0);
      tick();
      check("drain_in_ready2", bus.in_ready, 0);
      respond(0, 32'h5555_5555);
      check("drain_done", state_dbg, ST_IDLE);
      check("drain_no_out", bus.out_valid, 0);

      // flush beats acceptance
      bus.in_pc = 32'h400; bus.in_result = 32'h77; bus.in_is_load = 1'b0; bus.in_valid = 1'b1;
      flush = 1'b1;
      #1 check("flush_acc_ready", bus.in_ready, 1);
      tick();
      flush = 1'b0; bus.in_valid = 1'b0;
      check("flush_acc_drop", state_dbg, ST_IDLE);

      // flush together with the response in WAIT
      send(32'h500, 32'h500, 1'b1, LD_W, 1'b1, 5'd3);
      flush = 1'b1; rdata_valid = 1'b1; rdata = 32'h1;
      tick();
      flush = 1'b0; rdata_valid = 1'b0;
      check("flush_resp_idle", state_dbg, ST_IDLE);

      // LD_D on a 32-bit datapath behaves as a word load
      exp_q.push_back(32'h89AB_CDEF);
      send(32'h600, 32'h104, 1'b1, LD_D, 1'b1, 5'd6);
      respond(1, 32'h89AB_CDEF);
      check("ldd_wdata", bus.out_rf_wdata, 32'h89AB_CDEF);
      check("ldd_exc", exc_misalign, 0);
      tick();

      // misaligned LW from 0x101
      exp_q.push_back(32'h1122_3344);
      send(32'h700, 32'h101, 1'b1, LD_W, 1'b1, 5'd4);
      respond(0, 32'h1122_3344);
`ifdef MEM_ALIGN_EXC_EN
      check("mis_exc", exc_misalign, 1);
      check("mis_rf_we", bus.out_rf_we, 0);
      check("mis_fwd_we", fwd_we, 0);
`else
      check("mis_exc", exc_misalign, 0);
      check("mis_rf_we", bus.out_rf_we, 1);
      check("mis_lane0", bus.out_rf_wdata, 32'h1122_3344);
`endif
      tick();

      // reset in the middle of WAIT
      send(32'h800, 32'h800, 1'b1, LD_W, 1'b1, 5'd10);
      check("rstw_pending", fwd_pending, 1);
      rst = 1'b1;
      tick();
      check("rstw_state", state_dbg, ST_IDLE);
      check("rstw_in_ready", bus.in_ready, 0);
      rst = 1'b0;
      tick();
      check("rstw_ready_after", bus.in_ready, 1);

      repeat (2) tick();
      check("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
